// File: rtl/mem_access_unit.sv
// LC-3b MAR/MDR memory-access unit: clocked MAR/MDR, req/ack handshake to memory,
// byte lanes, bounded wait with timeout and word-alignment check.
module mem_access_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_mar,
    input  logic                     ld_mdr,
    input  logic                     mem_start,
    input  logic                     r_w,
    input  logic                     byte_mode,
    input  logic [DATA_W-1:0]        bus_in,
    output logic [ADDR_W-1:0]        mar_out,
    output logic [DATA_W-1:0]        mdr_out,
    output logic [DATA_W-1:0]        mdr_byte,
    output logic                     R,
    output logic                     busy,
    output logic                     err,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [DATA_W/8-1:0]      mem_wmask,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ack
);

    localparam int LANES = DATA_W / 8;
    localparam int LSB_W = $clog2(LANES);
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  mar;
    logic [DATA_W-1:0]  mdr;
    logic [CNT_W-1:0]   cnt;
    logic               byte_q;
    logic               we_q;
    logic               r_q;
    logic               err_q;
    logic               busy_q;
    logic               req_q;
    logic [ADDR_W-1:0]  mar_nxt;
    logic [LSB_W-1:0]   lane;
    logic [7:0]         sel;

    // A load coinciding with start must be seen by the alignment check
    assign mar_nxt = ld_mar ? bus_in[ADDR_W-1:0] : mar;
    assign lane    = mar[LSB_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            mar    <= '0;
            mdr    <= '0;
            cnt    <= '0;
            byte_q <= 1'b0;
            we_q   <= 1'b0;
            r_q    <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            req_q  <= 1'b0;
        end else begin
            r_q   <= 1'b0;
            err_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (ld_mar) mar <= bus_in[ADDR_W-1:0];
                    if (ld_mdr) mdr <= bus_in;
                    if (mem_start) begin
                        byte_q <= byte_mode;
                        if (!byte_mode && mar_nxt[LSB_W-1:0] != '0) begin
                            state <= S_DONE;
                            r_q   <= 1'b1;
                            err_q <= 1'b1;
                        end else begin
                            state  <= S_REQ;
                            busy_q <= 1'b1;
                            req_q  <= 1'b1;
                            we_q   <= r_w;
                        end
                    end
                end
                S_REQ: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // Ack is tested first so it wins over a same-cycle timeout
                    if (mem_ack || cnt == CNT_W'(TIMEOUT - 1)) begin
                        if (mem_ack && !we_q) mdr <= mem_rdata;
                        state  <= S_DONE;
                        r_q    <= 1'b1;
                        err_q  <= !mem_ack;
                        busy_q <= 1'b0;
                        req_q  <= 1'b0;
                        we_q   <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        sel      = mdr[8*lane +: 8];
        mdr_byte = {{(DATA_W-8){sel[7]}}, sel};
    end

    assign mar_out   = mar;
    assign mdr_out   = mdr;
    assign R         = r_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = {mar[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
    assign mem_wdata = byte_q ? {LANES{mdr[7:0]}} : mdr;
    assign mem_wmask = byte_q ? (LANES'(1) << lane) : {LANES{1'b1}};

endmodule
